// File: rtl/sdram_arbit_rr.sv
// SDRAM command arbiter: init pass-through, top-priority auto-refresh, round-robin user channels,
// grant-hold watchdog and combinational pin mux driven from the registered grant state.
module sdram_arbit_rr #(
   parameter int NCH      = 4,
   parameter int AW       = 13,
   parameter int BW       = 2,
   parameter int DW       = 16,
   parameter int HOLD_MAX = 1024,
   localparam int IW      = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              arb_clk,
   input  logic              arb_rst_n,
   input  logic [3:0]        init_cmd,
   input  logic [BW-1:0]     init_bank,
   input  logic [AW-1:0]     init_addr,
   input  logic              init_end,
   input  logic [3:0]        ar_cmd,
   input  logic [BW-1:0]     ar_bank,
   input  logic [AW-1:0]     ar_addr,
   input  logic              ar_req,
   input  logic              ar_end,
   input  logic [4*NCH-1:0]  ch_cmd,
   input  logic [BW*NCH-1:0] ch_bank,
   input  logic [AW*NCH-1:0] ch_addr,
   input  logic [NCH-1:0]    ch_req,
   input  logic [NCH-1:0]    ch_end,
   input  logic [NCH-1:0]    ch_dq_oe,
   input  logic [DW*NCH-1:0] ch_dq,
   output logic              ar_en,
   output logic [NCH-1:0]    ch_en,
   output logic [IW-1:0]     grant_idx,
   output logic              timeout_err,
   output logic              sdram_cke,
   output logic              sdram_cs_n,
   output logic              sdram_ras_n,
   output logic              sdram_cas_n,
   output logic              sdram_we_n,
   output logic [BW-1:0]     sdram_bank,
   output logic [AW-1:0]     sdram_addr,
   output logic [DW-1:0]     sdram_dq_o,
   output logic              sdram_dq_oe
);

   localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam bit WD_EN = (HOLD_MAX > 0);
   localparam logic [CW-1:0] HOLD_LIM = CW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_ARB, S_AR, S_CH} state_t;

   state_t          state, state_nxt;
   logic            ar_en_nxt, tmo_nxt;
   logic [NCH-1:0]  ch_en_nxt;
   logic [IW-1:0]   grant_nxt, rr_ptr, rr_nxt, pick, after_grant;
   logic [CW-1:0]   hold_cnt, hold_nxt;
   logic            wd_hit;
   logic [3:0]      pin_cmd;

   assign wd_hit      = WD_EN && (hold_cnt == HOLD_LIM);
   assign after_grant = (grant_idx == IW'(NCH - 1)) ? '0 : grant_idx + 1'b1;

   // Lowest rotational offset from rr_ptr wins; the descending loop lets it overwrite later hits.
   always_comb begin
      pick = rr_ptr;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (ch_req[(int'(rr_ptr) + i) % NCH]) pick = IW'((int'(rr_ptr) + i) % NCH);
      end
   end

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_nxt = state;
      ar_en_nxt = ar_en;
      ch_en_nxt = ch_en;
      grant_nxt = grant_idx;
      rr_nxt    = rr_ptr;
      hold_nxt  = hold_cnt;
      tmo_nxt   = 1'b0;
      case (state)
         S_IDLE: if (init_end) state_nxt = S_ARB;
         S_ARB: begin
            hold_nxt = '0;
            if (ar_req) begin
               state_nxt = S_AR;
               ar_en_nxt = 1'b1;
            end else if (|ch_req) begin
               state_nxt = S_CH;
               ch_en_nxt = NCH'(1) << pick;
               grant_nxt = pick;
            end
         end
         S_AR: begin
            hold_nxt = hold_cnt + 1'b1;
            if (ar_end || wd_hit) begin
               state_nxt = S_ARB;
               ar_en_nxt = 1'b0;
               tmo_nxt   = !ar_end;
            end
         end
         S_CH: begin
            hold_nxt = hold_cnt + 1'b1;
            if (ch_end[grant_idx] || wd_hit) begin
               state_nxt = S_ARB;
               ch_en_nxt = '0;
               rr_nxt    = after_grant;
               tmo_nxt   = !ch_end[grant_idx];
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; the async reset clears every register.
   always_ff @(posedge arb_clk or negedge arb_rst_n) begin
      if (!arb_rst_n) begin
         state       <= S_IDLE;
         ar_en       <= 1'b0;
         ch_en       <= '0;
         grant_idx   <= '0;
         timeout_err <= 1'b0;
         rr_ptr      <= '0;
         hold_cnt    <= '0;
      end else begin
         state       <= state_nxt;
         ar_en       <= ar_en_nxt;
         ch_en       <= ch_en_nxt;
         grant_idx   <= grant_nxt;
         timeout_err <= tmo_nxt;
         rr_ptr      <= rr_nxt;
         hold_cnt    <= hold_nxt;
      end
   end

   // Pins follow the registered state, so a grant switches the bus one cycle after the request.
   always_comb begin
      pin_cmd     = 4'b0111;
      sdram_bank  = '1;
      sdram_addr  = '1;
      sdram_dq_o  = '0;
      sdram_dq_oe = 1'b0;
      case (state)
         S_IDLE: begin
            pin_cmd    = init_cmd;
            sdram_bank = init_bank;
            sdram_addr = init_addr;
         end
         S_AR: begin
            pin_cmd    = ar_cmd;
            sdram_bank = ar_bank;
            sdram_addr = ar_addr;
         end
         S_CH: begin
            pin_cmd     = ch_cmd[4*grant_idx +: 4];
            sdram_bank  = ch_bank[BW*grant_idx +: BW];
            sdram_addr  = ch_addr[AW*grant_idx +: AW];
            sdram_dq_o  = ch_dq[DW*grant_idx +: DW];
            sdram_dq_oe = ch_dq_oe[grant_idx];
         end
         default: ;
      endcase
   end

   assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = pin_cmd;
   assign sdram_cke = 1'b1;

endmodule

// File: tb/tb_sdram_arbit_rr.sv
// Directed and randomized checks of sdram_arbit_rr against a transaction-level arbitration model.
module tb_sdram_arbit_rr;

   localparam int NCH  = 4;
   localparam int AW   = 13;
   localparam int BW   = 2;
   localparam int DW   = 16;
   localparam int HOLD = 8;
   localparam logic [3:0]    INIT_CMD  = 4'b0010;
   localparam logic [BW-1:0] INIT_BANK = 2'b01;
   localparam logic [AW-1:0] INIT_ADDR = 13'h0abc;
   localparam logic [18:0]   NOP_PINS  = {4'b0111, 2'b11, 13'h1fff};
   localparam logic [18:0]   INIT_PINS = {INIT_CMD, INIT_BANK, INIT_ADDR};

   logic arb_clk = 1'b0;
   logic arb_rst_n = 1'b0;
   logic init_end, ar_req, ar_end;
   logic [3:0] ar_cmd;
   logic [BW-1:0] ar_bank;
   logic [AW-1:0] ar_addr;
   logic [4*NCH-1:0] ch_cmd;
   logic [BW*NCH-1:0] ch_bank;
   logic [AW*NCH-1:0] ch_addr;
   logic [NCH-1:0] ch_req, ch_end, ch_dq_oe;
   logic [DW*NCH-1:0] ch_dq;
   logic ar_en, timeout_err, sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_dq_oe;
   logic [NCH-1:0] ch_en;
   logic [1:0] grant_idx;
   logic [BW-1:0] sdram_bank;
   logic [AW-1:0] sdram_addr;
   logic [DW-1:0] sdram_dq_o;

   logic [3:0]    r_cmd  [NCH];
   logic [BW-1:0] r_bank [NCH];
   logic [AW-1:0] r_addr [NCH];
   logic [DW-1:0] r_dq   [NCH];
   logic          r_oe   [NCH];

   int n_checks = 0;
   int n_errors = 0;
   int rr_model = 0;

   sdram_arbit_rr #(.NCH(NCH), .AW(AW), .BW(BW), .DW(DW), .HOLD_MAX(HOLD)) dut (
      .arb_clk(arb_clk), .arb_rst_n(arb_rst_n),
      .init_cmd(INIT_CMD), .init_bank(INIT_BANK), .init_addr(INIT_ADDR), .init_end(init_end),
      .ar_cmd(ar_cmd), .ar_bank(ar_bank), .ar_addr(ar_addr), .ar_req(ar_req), .ar_end(ar_end),
      .ch_cmd(ch_cmd), .ch_bank(ch_bank), .ch_addr(ch_addr), .ch_req(ch_req), .ch_end(ch_end),
      .ch_dq_oe(ch_dq_oe), .ch_dq(ch_dq),
      .ar_en(ar_en), .ch_en(ch_en), .grant_idx(grant_idx), .timeout_err(timeout_err),
      .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
      .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_bank(sdram_bank),
      .sdram_addr(sdram_addr), .sdram_dq_o(sdram_dq_o), .sdram_dq_oe(sdram_dq_oe)
   );

   always #5 arb_clk = ~arb_clk;

   always_comb begin
      ch_cmd = '0; ch_bank = '0; ch_addr = '0; ch_dq = '0; ch_dq_oe = '0;
      for (int k = 0; k < NCH; k++) begin
         ch_cmd[4*k +: 4]    = r_cmd[k];
         ch_bank[BW*k +: BW] = r_bank[k];
         ch_addr[AW*k +: AW] = r_addr[k];
         ch_dq[DW*k +: DW]   = r_dq[k];
         ch_dq_oe[k]         = r_oe[k];
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [18:0] pins();
      return {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_bank, sdram_addr};
   endfunction

   // Round-robin rule: first requester at or after the pointer, wrapping modulo NCH.
   function automatic int rr_pick(input logic [NCH-1:0] req, input int ptr);
      for (int off = 0; off < NCH; off++)
         if (req[(ptr + off) % NCH]) return (ptr + off) % NCH;
      return -1;
   endfunction

   task automatic tick();
      @(posedge arb_clk);
      #1;
   endtask

   task automatic randomize_fields();
      for (int k = 0; k < NCH; k++) begin
         r_cmd[k]  = 4'($urandom_range(0, 6));
         r_bank[k] = BW'($urandom);
         r_addr[k] = AW'($urandom);
         r_dq[k]   = DW'($urandom);
         r_oe[k]   = 1'($urandom_range(0, 1));
      end
      ar_bank = BW'($urandom);
      ar_addr = AW'($urandom);
   endtask

   task automatic check_idle_arb(input string tag);
      check({tag, " pins"}, 64'(pins()), 64'(NOP_PINS));
      check({tag, " en"}, 64'({ar_en, ch_en}), 64'(0));
      check({tag, " dq_oe"}, 64'(sdram_dq_oe), 64'(0));
   endtask

   task automatic check_ar(input string tag);
      check({tag, " ar_en/ch_en"}, 64'({ar_en, ch_en}), 64'({1'b1, 4'b0000}));
      check({tag, " pins"}, 64'(pins()), 64'({ar_cmd, ar_bank, ar_addr}));
      check({tag, " dq_oe"}, 64'(sdram_dq_oe), 64'(0));
   endtask

   task automatic check_ch(input string tag, input int k);
      check({tag, " ar_en/ch_en"}, 64'({ar_en, ch_en}), 64'({1'b0, 4'(1 << k)}));
      check({tag, " grant_idx"}, 64'(grant_idx), 64'(k));
      check({tag, " pins"}, 64'(pins()), 64'({r_cmd[k], r_bank[k], r_addr[k]}));
      check({tag, " dq"}, 64'({sdram_dq_oe, sdram_dq_o}), 64'({r_oe[k], r_dq[k]}));
   endtask

   // Entered one cycle into a channel grant; holds it h more cycles then ends, or lets the watchdog fire.
   task automatic serve_ch(input string tag, input int k, input int h, input bit hang);
      if (hang) begin
         repeat (HOLD - 1) begin
            tick();
            check_ch({tag, " held"}, k);
         end
         tick();
         check({tag, " tmo drop"}, 64'({ch_en, timeout_err}), 64'({4'b0000, 1'b1}));
         tick();
         check({tag, " tmo pulse end"}, 64'(timeout_err), 64'(0));
      end else begin
         repeat (h) begin
            tick();
            check_ch({tag, " held"}, k);
         end
         ch_end = 4'(1 << k);
         tick();
         ch_end = '0;
         check_idle_arb({tag, " end"});
         check({tag, " no tmo"}, 64'(timeout_err), 64'(0));
      end
      rr_model = (k + 1) % NCH;
   endtask

   task automatic serve_ar(input string tag, input int h, input bit hang);
      repeat (hang ? HOLD - 1 : h) begin
         tick();
         check_ar({tag, " held"});
      end
      ar_end = !hang;
      tick();
      ar_end = 1'b0;
      check_idle_arb({tag, " end"});
      check({tag, " tmo"}, 64'(timeout_err), 64'(hang));
   endtask

   initial begin
      automatic int order[5] = '{0, 1, 2, 3, 0};
      int k;
      logic a;
      logic [NCH-1:0] m;
      init_end = 1'b0; ar_req = 1'b0; ar_end = 1'b0; ar_cmd = 4'b0001;
      ch_req = '0; ch_end = '0;
      randomize_fields();

      // Reset values and IDLE pass-through of the init generator.
      #12;
      check("rst regs", 64'({ar_en, ch_en, grant_idx, timeout_err}), 64'(0));
      check("rst pins", 64'(pins()), 64'(INIT_PINS));
      check("rst dq_oe/cke", 64'({sdram_dq_oe, sdram_cke}), 64'(2'b01));
      @(negedge arb_clk);
      arb_rst_n = 1'b1;
      tick();
      tick();
      check("idle waits init_end", 64'(pins()), 64'(INIT_PINS));
      init_end = 1'b1;
      tick();
      init_end = 1'b0;
      check_idle_arb("arb after init");

      // All channels requesting: grants rotate 0,1,2,3,0 with one idle ARB cycle in between.
      ch_req = 4'hf;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_ch("t2 grant", order[i]);
         ch_end = 4'hf & ~4'(1 << order[i]);
         ar_end = 1'b1;
         tick();
         ch_end = '0;
         ar_end = 1'b0;
         check_ch("t2 stray end ignored", order[i]);
         tick();
         check_ch("t2 hold", order[i]);
         ch_end = 4'(1 << order[i]);
         tick();
         ch_end = '0;
         check_idle_arb("t2 idle between");
         rr_model = (order[i] + 1) % NCH;
      end
      ch_req = '0;

      // Refresh and channel 2 together: refresh first, pointer untouched, then channel 2.
      ar_req = 1'b1;
      ch_req = 4'b0100;
      tick();
      check_ar("t3 ar first");
      ar_req = 1'b0;
      tick();
      check_ar("t3 ar hold");
      ar_end = 1'b1;
      tick();
      ar_end = 1'b0;
      check_idle_arb("t3 after ar");
      tick();
      check_ch("t3 ch2", rr_pick(ch_req, rr_model));
      ch_req = '0;
      serve_ch("t3", 2, 1, 1'b0);

      // Refresh raised during channel 1: no pre-emption, refresh wins the next arbitration.
      ch_req = 4'b0010;
      tick();
      check_ch("t4 ch1", rr_pick(ch_req, rr_model));
      ar_req = 1'b1;
      tick();
      check_ch("t4 no preempt a", 1);
      tick();
      check_ch("t4 no preempt b", 1);
      ch_end = 4'b0010;
      tick();
      ch_end = '0;
      check_idle_arb("t4 arb re-entry");
      rr_model = 2;
      tick();
      check_ar("t4 ar wins");
      ar_req = 1'b0;
      ar_end = 1'b1;
      tick();
      ar_end = 1'b0;
      check_idle_arb("t4 ar done");
      tick();
      check_ch("t4 ch1 again", rr_pick(ch_req, rr_model));
      ch_req = '0;
      serve_ch("t4", 1, 0, 1'b0);

      // Watchdog: channel 0 never ends, then an end coincident with the limit on channel 1.
      ch_req = 4'b0001;
      tick();
      check_ch("t5 ch0", rr_pick(ch_req, rr_model));
      ch_req = 4'b0011;
      repeat (HOLD - 1) begin
         tick();
         check_ch("t5 ch0 held", 0);
         check("t5 no early tmo", 64'(timeout_err), 64'(0));
      end
      tick();
      check("t5 drop", 64'({ar_en, ch_en, timeout_err}), 64'({1'b0, 4'b0000, 1'b1}));
      check("t5 drop pins", 64'(pins()), 64'(NOP_PINS));
      rr_model = 1;
      tick();
      check("t5 pulse one cycle", 64'(timeout_err), 64'(0));
      check_ch("t5 ch1 next", rr_pick(ch_req, rr_model));
      ch_req = '0;
      serve_ch("t5 limit end", 1, HOLD - 1, 1'b0);

      // Asynchronous reset in the middle of a channel 3 grant driving dq.
      r_oe[3] = 1'b1;
      ch_req = 4'b1000;
      tick();
      check_ch("t6 ch3", rr_pick(ch_req, rr_model));
      ch_req = '0;
      #2;
      arb_rst_n = 1'b0;
      #1;
      check("t6 async drop", 64'({ar_en, ch_en, grant_idx, sdram_dq_oe}), 64'(0));
      check("t6 idle pins", 64'(pins()), 64'(INIT_PINS));
      tick();
      arb_rst_n = 1'b1;
      tick();
      check("t6 waits init_end", 64'(pins()), 64'(INIT_PINS));
      init_end = 1'b1;
      tick();
      init_end = 1'b0;
      check_idle_arb("t6 back to arb");
      rr_model = 0;

      // Randomized rounds against the arbitration model.
      for (int r = 0; r < 60; r++) begin
         randomize_fields();
         a = ($urandom_range(0, 3) == 0);
         m = 4'($urandom_range(0, 15));
         ar_req = a;
         ch_req = m;
         tick();
         ar_req = 1'b0;
         ch_req = '0;
         if (a) begin
            check_ar("rnd ar");
            serve_ar("rnd ar", $urandom_range(0, HOLD - 1), ($urandom_range(0, 5) == 0));
         end else if (m != 0) begin
            k = rr_pick(m, rr_model);
            check_ch("rnd ch", k);
            serve_ch("rnd ch", k, $urandom_range(0, HOLD - 1), ($urandom_range(0, 5) == 0));
         end else begin
            check_idle_arb("rnd none");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
